// File: rtl/rr_arb8.sv
// -----------------------------------------------------------------------------
// rr_arb8 -- 8-way round-robin arbiter with a bounded hold time
//
// The grant stays with one requester for as long as it keeps its request high.
// The exception is when it has held the resource for HOLD_MAX cycles while
// someone else is waiting: then the grant is taken away and tmo pulses. Every
// release is followed by a single dead cycle (GAP) before the next grant.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  arbiter enable; low drops any grant at the next edge
//   req        in   8  request lines, req[i] held high while i wants the bus
//   gnt        out  8  registered one-hot grant (all-zero when idle)
//   gnt_idx    out  3  registered index of the current or most recent grant
//   gnt_valid  out  1  registered, high exactly when gnt != 0
//   tmo        out  1  registered one-cycle pulse on a forced release
//
// States
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing granted, arbitrate whenever en=1 and req != 0
//   BUSY  | grant held on gnt_idx, hold counter running
//   GAP   | one dead cycle after a release, arbitrate for the next cycle
// -----------------------------------------------------------------------------
module rr_arb8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       tmo
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] hold_q;
    logic [7:0] hold_d;
    logic [2:0] last_q;
    logic [2:0] last_d;

    logic [7:0] gnt_d;
    logic [2:0] gnt_idx_d;
    logic       gnt_valid_d;
    logic       tmo_d;

    logic [2:0] scan_idx;
    logic       win_found;
    logic [2:0] win_idx;
    logic       any_req;
    logic [7:0] req_others;
    logic       hold_at_max;
    logic       rel_normal;
    logic       rel_forced;
    logic       do_grant;

    // -------------------------------------------------------------------------
    // Round-robin winner: first set request scanning upward from last+1.
    // The 3-bit add wraps naturally, so k=8 lands back on last itself and the
    // previous owner is considered only after everybody else.
    // -------------------------------------------------------------------------
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        scan_idx  = last_q;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = last_q + 3'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign any_req     = |req;
    assign req_others  = req & ~(8'd1 << gnt_idx);
    assign hold_at_max = (hold_q == HOLD_LIM);

    // Release conditions only matter in BUSY; requests changing on other
    // lines never disturb the current grant except through rel_forced.
    assign rel_normal  = !req[gnt_idx];
    assign rel_forced  = req[gnt_idx] && hold_at_max && (|req_others);
    assign do_grant    = en && any_req && win_found &&
                         ((state_q == ST_IDLE) || (state_q == ST_GAP));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rel_normal || rel_forced) begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP never lasts more than one cycle.
                    if (any_req) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values. Everything computed here is captured in
    // flops below, so req and en never reach a port combinationally.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = gnt_idx;
        tmo_d       = 1'b0;
        hold_d      = hold_q;
        last_d      = last_q;

        if (!en) begin
            // Drop the grant but remember who had it for fairness later.
            hold_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    hold_d = 8'd0;
                    if (do_grant) begin
                        gnt_d       = 8'd1 << win_idx;
                        gnt_valid_d = 1'b1;
                        gnt_idx_d   = win_idx;
                        last_d      = win_idx;
                    end
                end
                ST_BUSY: begin
                    if (rel_normal) begin
                        hold_d = 8'd0;
                    end else if (rel_forced) begin
                        hold_d = 8'd0;
                        tmo_d  = 1'b1;
                    end else begin
                        gnt_d       = gnt;
                        gnt_valid_d = 1'b1;
                        // Saturate so a lone requester can hold indefinitely
                        // and still be cut off the moment someone else asks.
                        if (!hold_at_max) begin
                            hold_d = hold_q + 8'd1;
                        end
                    end
                end
                default: begin
                    hold_d = 8'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            tmo       <= 1'b0;
            hold_q    <= 8'd0;
            // last=7 makes requester 0 the first in line after reset.
            last_q    <= 3'd7;
        end else begin
            gnt       <= gnt_d;
            gnt_idx   <= gnt_idx_d;
            gnt_valid <= gnt_valid_d;
            tmo       <= tmo_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

    localparam int HM = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       tmo;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arb8 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic       valid;
        logic [2:0] idx;
        logic       tmo;
    } vec_t;

    vec_t tbl[17];

    // reference model
    bit m_busy;
    int m_idx;
    int m_last;
    int m_held;
    bit m_tmo;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_idx  = 0;
        m_last = 7;
        m_held = 0;
        m_tmo  = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] r);
        logic [7:0] others;
        m_tmo = 0;
        if (!e) begin
            m_busy = 0;
            m_held = 0;
        end else if (m_busy) begin
            others = r & ~(8'd1 << m_idx);
            if (!r[m_idx]) begin
                m_busy = 0;
            end else if (m_held == HM && others != 0) begin
                m_busy = 0;
                m_tmo  = 1;
            end else if (m_held < HM) begin
                m_held++;
            end
        end else if (r != 0) begin
            // idle or gap cycle: both arbitrate for the following cycle
            m_idx  = pick(r, m_last);
            m_last = m_idx;
            m_held = 0;
            m_busy = 1;
        end
    endtask

    initial begin
        // release from reset: last=7 -> requester 2 only
        tbl[0]  = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
        tbl[1]  = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
        tbl[2]  = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b0};
        tbl[3]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd2, 1'b0};
        // last=2, req=09 -> idx 3, then idx 0
        tbl[5]  = '{1'b1, 8'h09, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[6]  = '{1'b1, 8'h09, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[7]  = '{1'b1, 8'h01, 8'h00, 1'b0, 3'd3, 1'b0};
        tbl[8]  = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
        // en low drops grant, index retained
        tbl[9]  = '{1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b0};
        // last=0, req=41 -> idx 6
        tbl[11] = '{1'b1, 8'h41, 8'h40, 1'b1, 3'd6, 1'b0};
        tbl[12] = '{1'b1, 8'h41, 8'h40, 1'b1, 3'd6, 1'b0};
        tbl[13] = '{1'b0, 8'h41, 8'h00, 1'b0, 3'd6, 1'b0};
        // last=6, req=41 -> idx 0
        tbl[14] = '{1'b1, 8'h41, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        // out of GAP straight to a new grant, last=0 -> idx 7
        tbl[16] = '{1'b1, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0};

        // ---------------- reset values ----------------
        do_reset();
        #1;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_idx", gnt_idx, 0);
        chk("reset_valid", gnt_valid, 0);
        chk("reset_tmo", tmo, 0);

        // ---------------- table vectors ----------------
        for (int v = 0; v < 17; v++) begin
            en  = tbl[v].en;
            req = tbl[v].req;
            tick();
            chk($sformatf("tbl_gnt[%0d]", v), gnt, tbl[v].gnt);
            chk($sformatf("tbl_valid[%0d]", v), gnt_valid, tbl[v].valid);
            chk($sformatf("tbl_idx[%0d]", v), gnt_idx, tbl[v].idx);
            chk($sformatf("tbl_tmo[%0d]", v), tmo, tbl[v].tmo);
        end

        // ---------------- all requesting: forced rotation ----------------
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        for (int g = 0; g <= 8; g++) begin
            for (int c = 0; c <= HM; c++) begin
                tick();
                chk($sformatf("rot_gnt[%0d.%0d]", g, c), gnt, 8'd1 << (g % 8));
                chk($sformatf("rot_tmo[%0d.%0d]", g, c), tmo, 0);
            end
            if (g < 8) begin
                tick();
                chk($sformatf("rot_gap_gnt[%0d]", g), gnt, 8'h00);
                chk($sformatf("rot_gap_tmo[%0d]", g), tmo, 1);
            end
        end

        // ---------------- lone requester holds past HOLD_MAX ----------------
        en  = 1'b0;
        tick();
        en  = 1'b1;
        req = 8'h20;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk($sformatf("lone_gnt[%0d]", c), gnt, 8'h20);
            chk($sformatf("lone_tmo[%0d]", c), tmo, 0);
        end
        req = 8'h00;
        tick();
        chk("lone_release", gnt, 8'h00);

        // ---------------- async reset mid-BUSY ----------------
        req = 8'h10;
        tick();
        tick();
        chk("arst_pre_gnt", gnt, 8'h10);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 8'h00);
        chk("arst_valid", gnt_valid, 0);
        chk("arst_idx", gnt_idx, 0);
        req = 8'h81;
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_first_gnt", gnt, 8'h01);
        chk("arst_first_idx", gnt_idx, 0);

        // ---------------- randomized against reference model ----------------
        do_reset();
        model_reset();
        en  = 1'b1;
        req = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [7:0] nreq;
            logic [7:0] exp_gnt;
            en = ($urandom_range(0, 24) != 0);
            nreq = req;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 23) == 0) nreq[b] = ~nreq[b];
            end
            req = nreq;
            @(posedge clk);
            model_step(en, req);
            #1;
            exp_gnt = m_busy ? (8'd1 << m_idx) : 8'h00;
            chk($sformatf("rnd_gnt[%0d]", cyc), gnt, exp_gnt);
            chk($sformatf("rnd_valid[%0d]", cyc), gnt_valid, m_busy);
            chk($sformatf("rnd_idx[%0d]", cyc), gnt_idx, m_idx);
            chk($sformatf("rnd_tmo[%0d]", cyc), tmo, m_tmo);
            chk($sformatf("rnd_onehot[%0d]", cyc), ($countones(gnt) <= 1), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum BUSY cycles one grant may hold while other requests are pending (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  arbiter enable, active-high; no new grant is issued while low.
REQ-005 req  input  8  request lines; req[i] is held high by requester i for as long as it wants the resource.
REQ-006 gnt  output  8  registered one-hot grant, gnt[i] for requester i; all-zero when nothing is granted.
REQ-007 gnt_idx  output  3  registered binary index of the granted requester (gnt = 3-to-8 decode of gnt_idx qualified by gnt_valid).
REQ-008 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 tmo  output  1  registered one-cycle pulse on a forced release due to HOLD_MAX.

Function
REQ-010 FSM states: IDLE (no grant), BUSY (grant held), GAP (one-cycle dead cycle after release, gnt=0).
REQ-011 IDLE: if en=1 and req!=0, select the winner and enter BUSY; the grant is visible at the next rising edge (1-cycle latency from req to gnt).
REQ-012 Winner: the first set bit of req scanning upward from (last+1) mod 8, wrapping 7->0; last = index of the most recent grant.
REQ-013 On every grant, last is updated to the winner's index and the hold counter is cleared to 0.
REQ-014 BUSY: gnt, gnt_idx and gnt_valid are held constant; the hold counter increments each cycle and saturates at HOLD_MAX.
REQ-015 BUSY -> GAP when req[gnt_idx]=0 (normal release), sampled at the clock edge; gnt drops at that edge.
REQ-016 BUSY -> GAP forced when the hold counter = HOLD_MAX and any other req bit is set; tmo=1 for that one cycle.
REQ-017 With the hold counter = HOLD_MAX and no other request pending, no release occurs; the grant continues and tmo stays 0.
REQ-018 GAP -> BUSY with a new winner per REQ-012 if en=1 and req!=0; otherwise GAP -> IDLE; GAP always lasts exactly one cycle.
REQ-019 A forced-release requester that keeps req high is re-arbitrated normally; it gets lowest priority because last equals its index.
REQ-020 en=0 in any state: at the next edge, gnt=0, gnt_valid=0 and state=IDLE; gnt_idx and last keep their values, the counter clears, and tmo=0.
REQ-021 Requests that arrive or drop while BUSY do not affect the current grant, except for REQ-015 and REQ-016.
REQ-022 At most one gnt bit is ever set; gnt_valid equals (gnt!=0) every cycle.
REQ-023 Outputs come from flops only; there is no combinational path from req or en to any output.

Reset
REQ-024 rst_n=0 immediately forces gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, tmo=0, state=IDLE, counter=0 and last=3'd7, so requester 0 has first priority.
REQ-025 Assertion of rst_n mid-BUSY drops the grant without waiting for a clock; after release, the first arbitration starts at priority 0.
REQ-026 Release of rst_n is synchronous in effect; the first arbitration occurs at the first rising edge with rst_n=1.

Verification
REQ-027 Reset, then en=1, req=8'hFF held -> grant sequence is idx 0,1,2,...,7,0 with each grant for HOLD_MAX+1 cycles, a 1-cycle GAP between grants, and tmo pulsing at each switch.
REQ-028 en=1, req=8'h04 for 3 cycles then 8'h00 -> gnt=8'h04 one edge after req rises, gnt=0 one edge after req falls, state ends in IDLE, tmo never 1.
REQ-029 last=2, req=8'h09 -> the next grant is idx 3 (gnt=8'h08); after release, idx 0 (gnt=8'h01).
REQ-030 Only req[5]=1 held for 40 cycles with HOLD_MAX=15 -> gnt=8'h20 continuously, no GAP, tmo=0.
REQ-031 BUSY on idx 6, then en=0 -> gnt=0 and gnt_valid=0 at the next edge, and gnt_idx stays 6; with en=1 again and req=8'h41 -> grant to idx 0.
REQ-032 rst_n pulsed low mid-BUSY between clock edges -> gnt=0 and gnt_valid=0 immediately; with req=8'h81 afterwards, the first grant is idx 0.
